// File: rtl/param_updown_counter.sv
`default_nettype none
// ============================================================================
//  Module      : param_updown_counter
//  Description : Parametrised up/down counter with configurable modulus
//                (MAX_VAL+1) and a wrap or saturate policy. It has terminal
//                flags and sticky overflow/underflow flags that software
//                clears.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    WIDTH      counter width in bits (2..32)
//    MAX_VAL    highest count value (1..2**WIDTH-1)
//    SATURATE   0 = wrap at the limits, 1 = hold at the limits
//  Ports
//    clk          rising-edge clock
//    rst_n        asynchronous reset, active-low
//    ld_i         load data_in_i (highest priority)
//    inc_i        count up by one
//    dec_i        count down by one (inc_i together with dec_i = hold)
//    data_in_i    load value; values above MAX_VAL clamp and raise overflow
//    clr_flags_i  clear the sticky ovf_o/unf_o flags on the next edge
//    data_out_o   current count (registered)
//    at_max_o     data_out_o == MAX_VAL
//    at_zero_o    data_out_o == 0
//    ovf_o        sticky overflow flag (registered)
//    unf_o        sticky underflow flag (registered)
// ============================================================================
module param_updown_counter #(
    parameter int          WIDTH    = 8,
    parameter int unsigned MAX_VAL  = (WIDTH >= 32) ? 32'hFFFF_FFFF
                                                    : ((32'd1 << WIDTH) - 32'd1),
    parameter bit          SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ld_i,
    input  logic             inc_i,
    input  logic             dec_i,
    input  logic [WIDTH-1:0] data_in_i,
    input  logic             clr_flags_i,
    output logic [WIDTH-1:0] data_out_o,
    output logic             at_max_o,
    output logic             at_zero_o,
    output logic             ovf_o,
    output logic             unf_o
);

    localparam logic [WIDTH-1:0] c_max  = WIDTH'(MAX_VAL);
    localparam logic [WIDTH:0]   c_max1 = {1'b0, c_max};
    localparam logic [WIDTH:0]   c_one1 = (WIDTH+1)'(1);

    logic [WIDTH-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    logic [WIDTH:0]   w_inc;
    logic [WIDTH:0]   w_dec;
    logic             w_ovf_evt;
    logic             w_unf_evt;

    // One extra bit of headroom: the increment result is compared against
    // the modulus limit, and the borrow bit of the decrement marks underflow.
    // Natural WIDTH rollover is never relied upon because the modulus is
    // generally not a power of two.
    assign w_inc = {1'b0, count_q} + c_one1;
    assign w_dec = {1'b0, count_q} - c_one1;

    always_comb begin
        count_d   = count_q;
        w_ovf_evt = 1'b0;
        w_unf_evt = 1'b0;

        if (ld_i) begin
            // A load masks inc/dec completely, including their flag effects.
            if (data_in_i > c_max) begin
                count_d   = c_max;
                w_ovf_evt = 1'b1;
            end else begin
                count_d   = data_in_i;
            end
        end else if (inc_i && !dec_i) begin
            if (w_inc > c_max1) begin
                w_ovf_evt = 1'b1;
                count_d   = SATURATE ? c_max : '0;
            end else begin
                count_d   = w_inc[WIDTH-1:0];
            end
        end else if (dec_i && !inc_i) begin
            if (w_dec[WIDTH]) begin
                w_unf_evt = 1'b1;
                count_d   = SATURATE ? '0 : c_max;
            end else begin
                count_d   = w_dec[WIDTH-1:0];
            end
        end

        // A set event on the same edge as a clear wins for that flag only.
        ovf_d = w_ovf_evt | (ovf_q & ~clr_flags_i);
        unf_d = w_unf_evt | (unf_q & ~clr_flags_i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign data_out_o = count_q;
    assign ovf_o      = ovf_q;
    assign unf_o      = unf_q;
    assign at_max_o   = (count_q == c_max);
    assign at_zero_o  = (count_q == '0);

`ifndef SYNTHESIS
    if (WIDTH < 2 || WIDTH > 32 || MAX_VAL == 0 ||
        ((64'(MAX_VAL) >> WIDTH) != 64'd0)) begin : g_bad_params
        $error("param_updown_counter: illegal WIDTH=%0d / MAX_VAL=%0d", WIDTH, MAX_VAL);
    end

    always_ff @(posedge clk) begin
        if (rst_n && w_ovf_evt) begin
            $warning("%m: overflow event, count=%0d", count_q);
        end
        if (rst_n && w_unf_evt) begin
            $warning("%m: underflow event, count=%0d", count_q);
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_param_updown_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_param_updown_counter
//  Description : Scoreboard bench driving three counter configurations
//                (4/9/wrap, 4/9/saturate, 8/255/wrap) with shared stimulus.
//                A behavioural model pushes the expected observation per
//                edge; a monitor pops and compares once per cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_param_updown_counter;

    localparam int c_w   [3] = '{4, 4, 8};
    localparam int c_max [3] = '{9, 9, 255};
    localparam int c_sat [3] = '{0, 1, 0};

    typedef struct packed {
        logic [7:0] cnt;
        logic       ovf;
        logic       unf;
        logic       amax;
        logic       azero;
    } obs_t;

    typedef struct packed {
        logic [7:0]      tag;
        obs_t [2:0]      d;
    } trio_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ld, inc, dec, clr;
    logic [7:0] data_in;

    logic [3:0] dout0, dout1;
    logic [7:0] dout2;
    logic       amax0, amax1, amax2;
    logic       azero0, azero1, azero2;
    logic       ovf0, ovf1, ovf2;
    logic       unf0, unf1, unf2;

    int errors = 0;
    int checks = 0;

    trio_t sb_q[$];

    // Reference model state
    int m_cnt [3];
    bit m_ovf [3];
    bit m_unf [3];

    always #5 clk = ~clk;

    param_updown_counter #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1'b0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .ld_i(ld), .inc_i(inc), .dec_i(dec),
        .data_in_i(data_in[3:0]), .clr_flags_i(clr), .data_out_o(dout0),
        .at_max_o(amax0), .at_zero_o(azero0), .ovf_o(ovf0), .unf_o(unf0)
    );

    param_updown_counter #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1'b1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .ld_i(ld), .inc_i(inc), .dec_i(dec),
        .data_in_i(data_in[3:0]), .clr_flags_i(clr), .data_out_o(dout1),
        .at_max_o(amax1), .at_zero_o(azero1), .ovf_o(ovf1), .unf_o(unf1)
    );

    param_updown_counter #(.WIDTH(8), .MAX_VAL(255), .SATURATE(1'b0)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .ld_i(ld), .inc_i(inc), .dec_i(dec),
        .data_in_i(data_in), .clr_flags_i(clr), .data_out_o(dout2),
        .at_max_o(amax2), .at_zero_o(azero2), .ovf_o(ovf2), .unf_o(unf2)
    );

    function automatic obs_t actual(input int k);
        obs_t o;
        case (k)
            0:       o = '{cnt: {4'd0, dout0}, ovf: ovf0, unf: unf0, amax: amax0, azero: azero0};
            1:       o = '{cnt: {4'd0, dout1}, ovf: ovf1, unf: unf1, amax: amax1, azero: azero1};
            default: o = '{cnt: dout2, ovf: ovf2, unf: unf2, amax: amax2, azero: azero2};
        endcase
        return o;
    endfunction

    function automatic void report(input int k, input int tag, input obs_t got, input obs_t want);
        $display("FAIL dut%0d tag=%0d: got cnt=%0d ovf=%b unf=%b at_max=%b at_zero=%b, want cnt=%0d ovf=%b unf=%b at_max=%b at_zero=%b",
                 k, tag, got.cnt, got.ovf, got.unf, got.amax, got.azero,
                 want.cnt, want.ovf, want.unf, want.amax, want.azero);
    endfunction

    // Drive one cycle of stimulus at the falling edge and push what each
    // configuration must show after the following rising edge.
    task automatic cyc(input bit rn, input bit l, input bit i, input bit d,
                       input bit c, input logic [7:0] din, input logic [7:0] tag);
        trio_t t;
        int    mx;
        int    dk;
        bit    so, su;
        @(negedge clk);
        rst_n   = rn;
        ld      = l;
        inc     = i;
        dec     = d;
        clr     = c;
        data_in = din;
        for (int k = 0; k < 3; k++) begin
            mx = c_max[k];
            dk = int'(din) % (1 << c_w[k]);
            so = 1'b0;
            su = 1'b0;
            if (!rn) begin
                m_cnt[k] = 0;
                m_ovf[k] = 1'b0;
                m_unf[k] = 1'b0;
            end else begin
                if (l) begin
                    if (dk > mx) begin
                        m_cnt[k] = mx;
                        so = 1'b1;
                    end else begin
                        m_cnt[k] = dk;
                    end
                end else if (i && !d) begin
                    if (m_cnt[k] == mx) begin
                        so = 1'b1;
                        m_cnt[k] = (c_sat[k] != 0) ? mx : 0;
                    end else begin
                        m_cnt[k] = m_cnt[k] + 1;
                    end
                end else if (d && !i) begin
                    if (m_cnt[k] == 0) begin
                        su = 1'b1;
                        m_cnt[k] = (c_sat[k] != 0) ? 0 : mx;
                    end else begin
                        m_cnt[k] = m_cnt[k] - 1;
                    end
                end
                m_ovf[k] = so | (m_ovf[k] & !c);
                m_unf[k] = su | (m_unf[k] & !c);
            end
            t.d[k].cnt   = 8'(m_cnt[k]);
            t.d[k].ovf   = m_ovf[k];
            t.d[k].unf   = m_unf[k];
            t.d[k].amax  = (m_cnt[k] == mx);
            t.d[k].azero = (m_cnt[k] == 0);
        end
        t.tag = tag;
        sb_q.push_back(t);
    endtask

    // Immediate check of the asynchronous reset state, between clock edges.
    task automatic chk_reset_now(input int tag);
        obs_t want;
        obs_t got;
        want = '{cnt: 8'd0, ovf: 1'b0, unf: 1'b0, amax: 1'b0, azero: 1'b1};
        for (int k = 0; k < 3; k++) begin
            got = actual(k);
            checks++;
            if (got !== want) begin
                errors++;
                report(k, tag, got, want);
            end
        end
    endtask

    // Monitor: one expected observation per rising edge while entries exist.
    initial begin : p_monitor
        trio_t t;
        obs_t  got;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() != 0) begin
                t = sb_q.pop_front();
                for (int k = 0; k < 3; k++) begin
                    got = actual(k);
                    checks++;
                    if (got !== t.d[k]) begin
                        errors++;
                        report(k, int'(t.tag), got, t.d[k]);
                    end
                end
            end
        end
    end

    initial begin : p_stim
        int r;
        rst_n   = 1'b0;
        ld      = 1'b0;
        inc     = 1'b0;
        dec     = 1'b0;
        clr     = 1'b0;
        data_in = 8'd0;
        for (int k = 0; k < 3; k++) begin
            m_cnt[k] = 0;
            m_ovf[k] = 1'b0;
            m_unf[k] = 1'b0;
        end
        #2;
        chk_reset_now(0);
        cyc(0, 0, 0, 0, 0, 8'd0, 8'd0);

        // Async reset mid-count at value 5
        cyc(1, 1, 0, 0, 0, 8'd5, 8'd1);
        cyc(1, 0, 0, 0, 0, 8'd0, 8'd1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk_reset_now(1);
        cyc(0, 0, 0, 0, 0, 8'd0, 8'd1);
        // First edge after release acts normally
        cyc(1, 0, 1, 0, 0, 8'd0, 8'd1);

        // Wrap up: ld 8, inc x3, flag persists until clear
        cyc(1, 1, 0, 0, 0, 8'd8, 8'd2);
        cyc(1, 0, 1, 0, 0, 8'd0, 8'd2);
        cyc(1, 0, 1, 0, 0, 8'd0, 8'd2);
        cyc(1, 0, 1, 0, 0, 8'd0, 8'd2);
        cyc(1, 0, 0, 0, 0, 8'd0, 8'd2);
        cyc(1, 0, 0, 0, 1, 8'd0, 8'd2);

        // Saturate down: ld 1, dec x3, then clr together with dec
        cyc(1, 1, 0, 0, 0, 8'd1, 8'd3);
        cyc(1, 0, 0, 1, 0, 8'd0, 8'd3);
        cyc(1, 0, 0, 1, 0, 8'd0, 8'd3);
        cyc(1, 0, 0, 1, 0, 8'd0, 8'd3);
        cyc(1, 0, 0, 1, 1, 8'd0, 8'd3);
        cyc(1, 0, 0, 0, 1, 8'd0, 8'd3);

        // Priority: load beats inc; inc with dec holds
        cyc(1, 1, 0, 0, 0, 8'd3, 8'd4);
        cyc(1, 1, 1, 0, 0, 8'd7, 8'd4);
        cyc(1, 0, 1, 1, 0, 8'd0, 8'd4);
        cyc(1, 1, 0, 1, 0, 8'd0, 8'd4);
        cyc(1, 0, 1, 1, 0, 8'd0, 8'd4);

        // Out-of-range load clamps and raises overflow
        cyc(1, 1, 0, 0, 0, 8'd12, 8'd5);
        cyc(1, 1, 0, 0, 1, 8'd15, 8'd5);
        cyc(1, 0, 0, 0, 1, 8'd0, 8'd5);

        // Random traffic
        for (int n = 0; n < 10000; n++) begin
            r = int'($urandom_range(0, 99));
            cyc(($urandom_range(0, 499) != 0),
                (r < 10),
                ($urandom_range(0, 99) < 45),
                ($urandom_range(0, 99) < 45),
                ($urandom_range(0, 99) < 6),
                8'($urandom),
                8'd6);
        end

        cyc(1, 0, 0, 0, 0, 8'd0, 8'd7);
        repeat (2) @(posedge clk);
        #2;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending entries, want 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
